// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Contents: FSM state encoding, RV32I opcode constants, ALUSel/ImmSel/WBSel codes,
//           and a helper that maps funct3/funct7 onto an ALUSel code.
// No logic beyond the combinational helper function.
package cu_pkg;

   // FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_e;

   // RV32I opcodes handled by the decoder
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALUSel codes (4-bit core code, zero-extended to ALUSEL_W at the top)
   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_XOR  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_ADD  = 4'd3;
   localparam logic [3:0] ALU_SLL  = 4'd4;
   localparam logic [3:0] ALU_SRA  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   // ImmSel codes
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_J = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_S = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // WBSel codes
   localparam logic [1:0] WB_MEM = 2'b00;
   localparam logic [1:0] WB_ALU = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   // funct3/funct7 -> ALUSel. sub_ok distinguishes R-type (funct7 picks add/sub)
   // from I-type (addi has no subtract form; funct7 only matters for shifts).
   function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                 input logic       f7,
                                                 input logic       sub_ok);
      logic [3:0] code;
      case (f3)
         3'b000:  code = (f7 && sub_ok) ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = f7 ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/cu_decoder.sv
// Purely combinational opcode/funct decoder for the multicycle control unit.
// Latency: zero (combinational). Backpressure: none; outputs follow inputs directly.
// Ports: opcode/funct3/funct7 + BrEq/BrLt in; datapath selects, class flags
//        (branch/load/store), jump-or-taken flag and a legal-opcode flag out.
module cu_decoder
   import cu_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_i,
   input  logic       br_eq_i,
   input  logic       br_lt_i,
   output logic [2:0] imm_sel_o,
   output logic       asel_o,
   output logic       bsel_o,
   output logic [3:0] alu_sel_o,
   output logic       br_un_o,
   output logic [1:0] wb_sel_o,
   output logic [1:0] store_sel_o,
   output logic [2:0] load_sel_o,
   output logic       pc_sel_o,     // redirect to ALU result when this insn retires
   output logic       is_branch_o,
   output logic       is_load_o,
   output logic       is_store_o,
   output logic       legal_o
);

   logic taken;

   // Branch condition; BrLt already reflects signedness chosen through BrUn.
   always_comb begin
      taken = 1'b0;
      case (funct3_i)
         3'b000:  taken =  br_eq_i;   // beq
         3'b001:  taken = !br_eq_i;   // bne
         3'b100:  taken =  br_lt_i;   // blt
         3'b101:  taken = !br_lt_i;   // bge
         3'b110:  taken =  br_lt_i;   // bltu
         3'b111:  taken = !br_lt_i;   // bgeu
         default: taken = 1'b0;
      endcase
   end

   // Unknown opcodes leave every select at 0 so they behave as a NOP.
   always_comb begin
      imm_sel_o   = IMM_I;
      asel_o      = 1'b0;
      bsel_o      = 1'b0;
      alu_sel_o   = ALU_AND;
      br_un_o     = 1'b0;
      wb_sel_o    = WB_MEM;
      store_sel_o = 2'b00;
      load_sel_o  = 3'b000;
      pc_sel_o    = 1'b0;
      is_branch_o = 1'b0;
      is_load_o   = 1'b0;
      is_store_o  = 1'b0;
      legal_o     = 1'b1;
      case (opcode_i)
         OP_R: begin
            alu_sel_o = alu_from_funct(funct3_i, funct7_i, 1'b1);
            wb_sel_o  = WB_ALU;
         end
         OP_I: begin
            alu_sel_o = alu_from_funct(funct3_i, funct7_i, 1'b0);
            imm_sel_o = IMM_I;
            bsel_o    = 1'b1;
            wb_sel_o  = WB_ALU;
         end
         OP_LOAD: begin
            imm_sel_o  = IMM_I;
            bsel_o     = 1'b1;
            alu_sel_o  = ALU_ADD;
            wb_sel_o   = WB_MEM;
            load_sel_o = funct3_i;
            is_load_o  = 1'b1;
         end
         OP_STORE: begin
            imm_sel_o   = IMM_S;
            bsel_o      = 1'b1;
            alu_sel_o   = ALU_ADD;
            store_sel_o = funct3_i[1:0];
            is_store_o  = 1'b1;
         end
         OP_BRANCH: begin
            imm_sel_o   = IMM_B;
            asel_o      = 1'b1;
            bsel_o      = 1'b1;
            alu_sel_o   = ALU_ADD;
            br_un_o     = funct3_i[2] & funct3_i[1];
            pc_sel_o    = taken;
            is_branch_o = 1'b1;
         end
         OP_JAL: begin
            imm_sel_o = IMM_J;
            asel_o    = 1'b1;
            bsel_o    = 1'b1;
            alu_sel_o = ALU_ADD;
            wb_sel_o  = WB_PC4;
            pc_sel_o  = 1'b1;
         end
         OP_JALR: begin
            imm_sel_o = IMM_I;
            bsel_o    = 1'b1;
            alu_sel_o = ALU_ADD;
            wb_sel_o  = WB_PC4;
            pc_sel_o  = 1'b1;
         end
         OP_LUI: begin
            imm_sel_o = IMM_U;
            wb_sel_o  = WB_IMM;
         end
         OP_AUIPC: begin
            imm_sel_o = IMM_U;
            asel_o    = 1'b1;
            bsel_o    = 1'b1;
            alu_sel_o = ALU_ADD;
            wb_sel_o  = WB_ALU;
         end
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared memory port.
// Latency (no wait): branch 3, ALU/lui/auipc/jal/jalr 4, store 4, load 5 cycles; +1 per wait.
// Backpressure: mem_req held until mem_ready; watchdog aborts after WAIT_MAX wait cycles.
// Ports: clk/rst (sync, active-high); IR fields + BrEq/BrLt; mem_req/mem_ready handshake;
//        datapath controls; insn_done retire pulse, mem_err abort pulse, illegal_insn flag.
// Build option: define ILLEGAL_TRAP_EN to trap unknown opcodes; otherwise they retire as NOPs.
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int ALUSEL_W = 4,
   parameter int WAIT_MAX = 15
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic                funct7,
   input  logic                BrEq,
   input  logic                BrLt,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                IRWrite,
   output logic                PCWrite,
   output logic                PCSel,
   output logic [2:0]          ImmSel,
   output logic                RegWEn,
   output logic                Asel,
   output logic                Bsel,
   output logic [ALUSEL_W-1:0] ALUSel,
   output logic                BrUn,
   output logic                MemW,
   output logic [1:0]          WBSel,
   output logic [1:0]          Store_Select,
   output logic [2:0]          Load_Select,
   output logic                insn_done,
   output logic                mem_err,
   output logic                illegal_insn
);

   localparam logic [7:0] WAIT_TOP  = 8'(WAIT_MAX);
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;

   logic [2:0] dec_imm_sel;
   logic       dec_asel, dec_bsel, dec_br_un, dec_pc_sel;
   logic [3:0] dec_alu_sel;
   logic [1:0] dec_wb_sel, dec_store_sel;
   logic [2:0] dec_load_sel;
   logic       dec_is_branch, dec_is_load, dec_is_store, dec_legal;

   logic mem_phase, mem_done, wd_abort, exec_retire, retire, dec_act;

   cu_decoder u_dec (
      .opcode_i    (opcode),
      .funct3_i    (funct3),
      .funct7_i    (funct7),
      .br_eq_i     (BrEq),
      .br_lt_i     (BrLt),
      .imm_sel_o   (dec_imm_sel),
      .asel_o      (dec_asel),
      .bsel_o      (dec_bsel),
      .alu_sel_o   (dec_alu_sel),
      .br_un_o     (dec_br_un),
      .wb_sel_o    (dec_wb_sel),
      .store_sel_o (dec_store_sel),
      .load_sel_o  (dec_load_sel),
      .pc_sel_o    (dec_pc_sel),
      .is_branch_o (dec_is_branch),
      .is_load_o   (dec_is_load),
      .is_store_o  (dec_is_store),
      .legal_o     (dec_legal)
   );

   // Memory port is owned in FETCH and MEM only; mem_ready elsewhere is ignored.
   assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
   assign mem_done  = mem_phase && mem_ready;
   // Abort on the WAIT_MAX-th consecutive wait cycle, i.e. the edge where the count would reach WAIT_MAX.
   assign wd_abort  = mem_phase && !mem_ready && (wait_cnt_q >= WAIT_LAST);

   // Branches and (non-trapping) unknown opcodes have nothing left to do after EXEC.
   assign exec_retire = (state_q == ST_EXEC) && (dec_is_branch || !dec_legal);
   assign retire      = exec_retire
                      || ((state_q == ST_MEM) && dec_is_store && mem_ready)
                      || (state_q == ST_WB);

   assign dec_act = (state_q == ST_DECODE) || (state_q == ST_EXEC)
                 || (state_q == ST_MEM)    || (state_q == ST_WB);

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Watchdog counter: counts stalled request cycles, clears on completion/abort/idle port.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!mem_phase || mem_ready || wd_abort) begin
         wait_cnt_d = 8'd0;
      end else if (wait_cnt_q != WAIT_TOP) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: begin
            if (mem_done)      state_d = ST_DECODE;
            else if (wd_abort) state_d = ST_FETCH;
         end
         ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = dec_legal ? ST_EXEC : ST_TRAP;
`else
            state_d = ST_EXEC;
`endif
         end
         ST_EXEC: begin
            if (exec_retire)                      state_d = ST_FETCH;
            else if (dec_is_load || dec_is_store) state_d = ST_MEM;
            else                                  state_d = ST_WB;
         end
         ST_MEM: begin
            if (mem_done)      state_d = dec_is_load ? ST_WB : ST_FETCH;
            else if (wd_abort) state_d = ST_FETCH;  // store/load restarts from its fetch
         end
         ST_WB:   state_d = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
         ST_TRAP: state_d = ST_TRAP;                // only rst leaves the trap
`else
         ST_TRAP: state_d = ST_IDLE;                // unreachable in this build
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // Everything is forced low while rst is high so an aborted instruction never writes.
   always_comb begin
      mem_req      = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      PCSel        = 1'b0;
      ImmSel       = 3'b000;
      RegWEn       = 1'b0;
      Asel         = 1'b0;
      Bsel         = 1'b0;
      ALUSel       = '0;
      BrUn         = 1'b0;
      MemW         = 1'b0;
      WBSel        = 2'b00;
      Store_Select = 2'b00;
      Load_Select  = 3'b000;
      insn_done    = 1'b0;
      mem_err      = 1'b0;
      illegal_insn = 1'b0;
      if (!rst) begin
         mem_req   = mem_phase;
         IRWrite   = (state_q == ST_FETCH) && mem_ready;
         MemW      = (state_q == ST_MEM) && dec_is_store;
         RegWEn    = (state_q == ST_WB);
         PCWrite   = retire;
         insn_done = retire;
         PCSel     = retire && dec_pc_sel;
         mem_err   = wd_abort;
         if (dec_act) begin
            ImmSel       = dec_imm_sel;
            Asel         = dec_asel;
            Bsel         = dec_bsel;
            ALUSel       = ALUSEL_W'(dec_alu_sel);
            BrUn         = dec_br_un;
            WBSel        = dec_wb_sel;
            Store_Select = dec_store_sel;
            Load_Select  = dec_load_sel;
         end
`ifdef ILLEGAL_TRAP_EN
         illegal_insn = (state_q == ST_TRAP);
`endif
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

   localparam int WM = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7, BrEq, BrLt, mem_ready;
   logic       mem_req, IRWrite, PCWrite, PCSel, RegWEn, Asel, Bsel, BrUn, MemW;
   logic [2:0] ImmSel, Load_Select;
   logic [3:0] ALUSel;
   logic [1:0] WBSel, Store_Select;
   logic       insn_done, mem_err, illegal_insn;

   logic [25:0] outs;
   assign outs = {mem_req, IRWrite, PCWrite, PCSel, ImmSel, RegWEn, Asel, Bsel, ALUSel,
                  BrUn, MemW, WBSel, Store_Select, Load_Select, insn_done, mem_err, illegal_insn};

   int n_tests = 0;
   int n_fail  = 0;

   int         d_cyc, e_cyc, pcw_n;
   logic [3:0] alu_d;
   logic [1:0] wb_d;
   logic [2:0] ld_d;
   logic       pcsel_d, regwen_d, memw_any, brun_d;

   always #5 clk = ~clk;

   multicycle_control_unit #(.ALUSEL_W(4), .WAIT_MAX(WM)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .BrEq(BrEq), .BrLt(BrLt), .mem_ready(mem_ready), .mem_req(mem_req),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSel(PCSel), .ImmSel(ImmSel),
      .RegWEn(RegWEn), .Asel(Asel), .Bsel(Bsel), .ALUSel(ALUSel), .BrUn(BrUn),
      .MemW(MemW), .WBSel(WBSel), .Store_Select(Store_Select), .Load_Select(Load_Select),
      .insn_done(insn_done), .mem_err(mem_err), .illegal_insn(illegal_insn)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction from FETCH entry. rdy bit c drives mem_ready in cycle c (FETCH = cycle 0).
   // Returns the retire cycle (-1 if none) and the abort cycle (-1 if none), plus retire-time outputs.
   task automatic exec_insn(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input logic beq, input logic blt, input logic [39:0] rdy,
                            output int done_c, output int err_c, output int pcw_c,
                            output logic [3:0] alu_o, output logic [1:0] wb_o,
                            output logic pcsel_o, output logic regwen_o, output logic memw_o,
                            output logic [2:0] ld_o, output logic brun_o);
      done_c = -1; err_c = -1; pcw_c = 0;
      alu_o = '0; wb_o = '0; pcsel_o = 0; regwen_o = 0; memw_o = 0; ld_o = '0; brun_o = 0;
      opcode = opc; funct3 = f3; funct7 = f7; BrEq = beq; BrLt = blt;
      for (int c = 0; c < 40; c++) begin
         mem_ready = rdy[c];
         #1;
         if (MemW) memw_o = 1'b1;
         if (PCWrite) pcw_c++;
         if (insn_done) begin
            done_c = c; alu_o = ALUSel; wb_o = WBSel; pcsel_o = PCSel;
            regwen_o = RegWEn; ld_o = Load_Select; brun_o = BrUn;
         end
         if (mem_err) err_c = c;
         @(posedge clk);
         #1;
         if (done_c >= 0 || err_c >= 0) break;
      end
      mem_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; opcode = '0; funct3 = '0; funct7 = 1'b0;
      BrEq = 1'b0; BrLt = 1'b0; mem_ready = 1'b0;

      // ---- reset ----
      tick();
      chk("rst_all0", 32'(outs), 0);
      tick();
      rst = 1'b0;
      #1;
      chk("idle_all0", 32'(outs), 0);
      tick();
      chk("fetch_memreq", mem_req, 1);
      chk("fetch_noirw", IRWrite, 0);

      // ---- add, mem_ready tied high ----
      opcode = 7'b0110011; funct3 = 3'b000; funct7 = 1'b0; mem_ready = 1'b1;
      #1;
      chk("add_f_irw", IRWrite, 1);
      chk("add_f_alu0", ALUSel, 0);
      tick();
      chk("add_d_alu", ALUSel, 3);
      chk("add_d_memreq", mem_req, 0);
      tick();
      chk("add_e_noretire", {RegWEn, PCWrite, insn_done}, 3'b000);
      tick();
      chk("add_wb_retire", {RegWEn, PCWrite, insn_done, PCSel}, 4'b1110);
      chk("add_wb_wbsel", WBSel, 2'b01);
      tick();

      // ---- reset in WB aborts without a write ----
      chk("rst2_fetch", mem_req, 1);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk("rst_wb_nowrite", 32'(outs), 0);
      tick();
      rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk("rst_wb_idle", 32'(outs), 0);
      tick();

      // ---- lw with two wait cycles in MEM: retire in cycle 6 ----
      exec_insn(7'b0000011, 3'b010, 1'b0, 0, 0, 40'h21, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("lw_done_cyc", d_cyc, 6);
      chk("lw_memw", memw_any, 0);
      chk("lw_ldsel", ld_d, 3'b010);
      chk("lw_wb_regwen", {regwen_d, wb_d}, 3'b100);

      // ---- branches ----
      exec_insn(7'b1100011, 3'b001, 1'b0, 0, 0, 40'h1, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("bne_t_cyc", d_cyc, 2);
      chk("bne_t_pcsel", pcsel_d, 1);
      chk("bne_t_regwen", regwen_d, 0);
      exec_insn(7'b1100011, 3'b001, 1'b0, 1, 0, 40'h1, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("bne_nt_pcsel", pcsel_d, 0);
      chk("bne_nt_pcw", pcw_n, 1);
      exec_insn(7'b1100011, 3'b100, 1'b0, 0, 1, 40'h1, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("blt_t", {pcsel_d, brun_d}, 2'b10);
      exec_insn(7'b1100011, 3'b111, 1'b0, 0, 1, 40'h1, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("bgeu_nt", {pcsel_d, brun_d}, 2'b01);

      // ---- other ALU/jump decode ----
      exec_insn(7'b0110011, 3'b000, 1'b1, 0, 0, 40'h1, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("sub_alu", alu_d, 2);
      exec_insn(7'b0010011, 3'b101, 1'b1, 0, 0, 40'h1, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("srai_alu", alu_d, 5);
      exec_insn(7'b1101111, 3'b000, 1'b0, 0, 0, 40'h1, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("jal_cyc", d_cyc, 3);
      chk("jal_pc_wb", {pcsel_d, wb_d}, 3'b110);
      exec_insn(7'b0110111, 3'b000, 1'b0, 0, 0, 40'h1, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("lui_pc_wb", {pcsel_d, wb_d}, 3'b011);

      // ---- sw, no wait: retire in MEM at cycle 3 ----
      exec_insn(7'b0100011, 3'b010, 1'b0, 0, 0, 40'h9, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("sw_cyc", d_cyc, 3);
      chk("sw_memw_regwen", {memw_any, regwen_d}, 2'b10);

      // ---- sw with mem_ready stuck low: watchdog abort ----
      exec_insn(7'b0100011, 3'b010, 1'b0, 0, 0, 40'h1, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("wd_err_cyc", e_cyc, 3 + WM - 1);
      chk("wd_no_retire", d_cyc, -1);
      chk("wd_no_pcw", pcw_n, 0);
      #1;
      chk("wd_refetch", {mem_req, PCWrite, mem_err}, 3'b100);
      // retried store with one wait cycle after the abort
      exec_insn(7'b0100011, 3'b000, 1'b0, 0, 0, 40'h11, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("sw_retry_cyc", d_cyc, 4);

      // ---- unknown opcode ----
`ifdef ILLEGAL_TRAP_EN
      opcode = 7'b1111111; funct3 = 3'b000; mem_ready = 1'b1;
      #1;
      tick();
      mem_ready = 1'b0;
      tick();
      chk("trap_enter", 32'(outs), 1);
      repeat (5) tick();
      chk("trap_hold", 32'(outs), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("trap_rst_idle", 32'(outs), 0);
`else
      exec_insn(7'b1111111, 3'b000, 1'b0, 0, 0, 40'h1, d_cyc, e_cyc, pcw_n,
                alu_d, wb_d, pcsel_d, regwen_d, memw_any, ld_d, brun_d);
      chk("nop_cyc", d_cyc, 2);
      chk("nop_pcsel_regwen", {pcsel_d, regwen_d}, 2'b00);
      chk("nop_illegal", illegal_insn, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
